// File: rtl/control_unit.sv
// Single-cycle RV32I subset control unit: main decoder, ALU decoder,
// branch resolve and a sticky illegal-opcode status flag.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_bit5,
    input  logic       Zero,
    output logic       PCSrc,
    output logic       ResultSrc,
    output logic       MemWrite,
    output logic [2:0] ALUControl,
    output logic       ALUSrc,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       IllegalOp
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic       branch;
    logic [1:0] alu_op;
    logic       op_legal;

    // Main decoder: unknown opcodes fall through to an all-zero no-op.
    always_comb begin
        RegWrite  = 1'b0;
        ImmSrc    = 2'b00;
        ALUSrc    = 1'b0;
        MemWrite  = 1'b0;
        ResultSrc = 1'b0;
        branch    = 1'b0;
        alu_op    = ALUOP_ADD;
        op_legal  = 1'b1;
        case (op)
            OP_LW: begin
                RegWrite  = 1'b1;
                ALUSrc    = 1'b1;
                ResultSrc = 1'b1;
            end
            OP_SW: begin
                ImmSrc   = 2'b01;
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            OP_R: begin
                RegWrite = 1'b1;
                alu_op   = ALUOP_FUNC;
            end
            OP_IALU: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                alu_op   = ALUOP_FUNC;
            end
            OP_BEQ: begin
                ImmSrc = 2'b10;
                branch = 1'b1;
                alu_op = ALUOP_SUB;
            end
            default: op_legal = 1'b0;
        endcase
    end

    // ALU decoder: sub only for R-type with funct7[5] set (addi has no sub).
    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000:
                        ALUControl = (op[5] && funct7_bit5) ? ALU_SUB
                                                            : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

    assign PCSrc = branch & Zero;

    // Sticky status flag; reset wins over a simultaneous illegal opcode.
    always_ff @(posedge clk) begin
        if (reset) begin
            IllegalOp <= 1'b0;
        end else if (!op_legal) begin
            IllegalOp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed cases plus randomized
// decode and status-flag checks against a behavioural reference model.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7_bit5 = 1'b0;
    logic       Zero = 1'b0;
    logic       PCSrc;
    logic       ResultSrc;
    logic       MemWrite;
    logic [2:0] ALUControl;
    logic       ALUSrc;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       IllegalOp;

    int tests = 0;
    int fails = 0;
    bit ill_model = 1'b0;

    control_unit dut (
        .clk(clk),
        .reset(reset),
        .op(op),
        .funct3(funct3),
        .funct7_bit5(funct7_bit5),
        .Zero(Zero),
        .PCSrc(PCSrc),
        .ResultSrc(ResultSrc),
        .MemWrite(MemWrite),
        .ALUControl(ALUControl),
        .ALUSrc(ALUSrc),
        .ImmSrc(ImmSrc),
        .RegWrite(RegWrite),
        .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    // Vector layout: {PCSrc,ResultSrc,MemWrite,ALUControl,ALUSrc,ImmSrc,RegWrite}
    function automatic logic [9:0] actual();
        return {PCSrc, ResultSrc, MemWrite, ALUControl, ALUSrc, ImmSrc,
                RegWrite};
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011,
                         7'b0010011, 7'b1100011};
    endfunction

    // Reference model built from instruction semantics.
    function automatic logic [9:0] model(input logic [6:0] o,
                                         input logic [2:0] f3,
                                         input logic f7,
                                         input logic z);
        logic pc, rs, mw, src, rw;
        logic [2:0] alu;
        logic [1:0] imm;
        bit arith;
        pc = 0; rs = 0; mw = 0; src = 0; rw = 0; alu = 3'd0; imm = 2'd0;
        arith = 0;
        if (o == 7'b0000011) begin
            rw = 1; src = 1; rs = 1;
        end else if (o == 7'b0100011) begin
            mw = 1; src = 1; imm = 2'd1;
        end else if (o == 7'b0110011) begin
            rw = 1; arith = 1;
        end else if (o == 7'b0010011) begin
            rw = 1; src = 1; arith = 1;
        end else if (o == 7'b1100011) begin
            imm = 2'd2; alu = 3'd1; pc = z;
        end
        if (arith) begin
            if (f3 == 3'b010) alu = 3'b101;
            else if (f3 == 3'b110) alu = 3'b011;
            else if (f3 == 3'b111) alu = 3'b010;
            else if (f3 == 3'b000 && o == 7'b0110011 && f7) alu = 3'b001;
            else alu = 3'b000;
        end
        return {pc, rs, mw, alu, src, imm, rw};
    endfunction

    task automatic drive(input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic z);
        op = o;
        funct3 = f3;
        funct7_bit5 = f7;
        Zero = z;
        #1;
    endtask

    // One clock edge; the flag model follows the edge with the same inputs.
    task automatic tick();
        @(posedge clk);
        if (reset) ill_model = 1'b0;
        else if (!is_legal(op)) ill_model = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(7'b1111111, 3'd0, 1'b0, 1'b0);
        tick();
        tests++;
        if (IllegalOp !== 1'b0) begin
            fails++;
            $display("FAIL reset_priority got=%b exp=0", IllegalOp);
        end
        reset = 1'b0;
    endtask

    task automatic test_lw_sw();
        logic [9:0] exp;
        drive(7'b0000011, 3'b010, 1'b0, 1'b0);
        exp = 10'b0_1_0_000_1_00_1;
        tests++;
        if (actual() !== exp) begin
            fails++;
            $display("FAIL lw got=%b exp=%b", actual(), exp);
        end
        drive(7'b0100011, 3'b010, 1'b0, 1'b1);
        exp = 10'b0_0_1_000_1_01_0;
        tests++;
        if (actual() !== exp) begin
            fails++;
            $display("FAIL sw got=%b exp=%b", actual(), exp);
        end
    endtask

    task automatic test_rtype();
        logic [2:0] f3s [5] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010};
        logic       f7s [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0] alus[5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
        for (int i = 0; i < 5; i++) begin
            drive(7'b0110011, f3s[i], f7s[i], 1'b1);
            tests++;
            if (ALUControl !== alus[i] || RegWrite !== 1'b1 ||
                ALUSrc !== 1'b0 || MemWrite !== 1'b0 || PCSrc !== 1'b0) begin
                fails++;
                $display("FAIL rtype_%0d got=%b exp_alu=%b", i, actual(),
                         alus[i]);
            end
        end
    endtask

    task automatic test_beq();
        for (int z = 0; z < 2; z++) begin
            drive(7'b1100011, 3'b000, 1'b0, z[0]);
            tests++;
            if (actual() !== {z[0], 9'b0_0_001_0_10_0}) begin
                fails++;
                $display("FAIL beq_z%0d got=%b exp=%b", z, actual(),
                         {z[0], 9'b0_0_001_0_10_0});
            end
        end
    endtask

    task automatic test_addi();
        drive(7'b0010011, 3'b000, 1'b1, 1'b0);
        tests++;
        if (ALUControl !== 3'b000 || ALUSrc !== 1'b1 || RegWrite !== 1'b1) begin
            fails++;
            $display("FAIL addi_no_sub got=%b exp_alu=000", actual());
        end
    endtask

    task automatic test_sticky();
        reset = 1'b1;
        drive(7'b0000011, 3'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tests++;
        if (IllegalOp !== 1'b0) begin
            fails++;
            $display("FAIL sticky_reset1 got=%b exp=0", IllegalOp);
        end
        drive(7'b1111111, 3'd0, 1'b0, 1'b1);
        tests++;
        if (RegWrite !== 1'b0 || MemWrite !== 1'b0 || PCSrc !== 1'b0) begin
            fails++;
            $display("FAIL illegal_noop got=%b exp=RegWrite/MemWrite/PCSrc 0",
                     actual());
        end
        tick();
        tests++;
        if (IllegalOp !== 1'b1) begin
            fails++;
            $display("FAIL sticky_set got=%b exp=1", IllegalOp);
        end
        drive(7'b0000011, 3'b010, 1'b0, 1'b0);
        tick();
        tick();
        tests++;
        if (IllegalOp !== 1'b1) begin
            fails++;
            $display("FAIL sticky_hold got=%b exp=1", IllegalOp);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (IllegalOp !== 1'b0) begin
            fails++;
            $display("FAIL sticky_reset2 got=%b exp=0", IllegalOp);
        end
    endtask

    task automatic test_random();
        logic [6:0] legal [5] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                  7'b0010011, 7'b1100011};
        logic [6:0] o;
        logic [9:0] exp;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) o = 7'($urandom);
            else o = legal[$urandom_range(0, 4)];
            reset = ($urandom_range(0, 15) == 0);
            drive(o, 3'($urandom), 1'($urandom), 1'($urandom));
            exp = model(op, funct3, funct7_bit5, Zero);
            tests++;
            if (actual() !== exp) begin
                fails++;
                $display("FAIL rand_decode_%0d op=%b f3=%b f7=%b z=%b got=%b exp=%b",
                         i, op, funct3, funct7_bit5, Zero, actual(), exp);
            end
            tick();
            tests++;
            if (IllegalOp !== ill_model) begin
                fails++;
                $display("FAIL rand_flag_%0d got=%b exp=%b", i, IllegalOp,
                         ill_model);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw_sw();
        test_rtype();
        test_beq();
        test_addi();
        test_sticky();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed as listed below.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-003 clk  input  1  rising-edge clock; used only by the status register.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 op  input  7  instruction opcode, bits [6:0].
REQ-006 funct3  input  3  instruction bits [14:12].
REQ-007 funct7_bit5  input  1  instruction bit 30.
REQ-008 Zero  input  1  ALU zero flag.
REQ-009 PCSrc  output  1  1 = take branch target.
REQ-010 ResultSrc  output  1  1 = write back memory read data; 0 = write back ALU result.
REQ-011 MemWrite  output  1  data memory write enable.
REQ-012 ALUControl  output  3  ALU operation select.
REQ-013 ALUSrc  output  1  1 = ALU operand B is the immediate.
REQ-014 ImmSrc  output  2  immediate format select: 00 = I, 01 = S, 10 = B.
REQ-015 RegWrite  output  1  register file write enable.
REQ-016 IllegalOp  output  1  sticky, registered flag for an unsupported opcode.

Function
REQ-017 All outputs except IllegalOp SHALL be purely combinational functions of op, funct3, funct7_bit5 and Zero, with zero latency and independent of clk and reset.
REQ-018 The main decoder SHALL produce RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch and a 2-bit internal ALUOp as follows:
- lw (0000011): 1, 00, 1, 0, 1, 0, ALUOp 00.
- sw (0100011): 0, 01, 1, 1, 0, 0, ALUOp 00.
- R-type (0110011): 1, 00, 0, 0, 0, 0, ALUOp 10.
- I-ALU (0010011): 1, 00, 1, 0, 0, 0, ALUOp 10.
- beq (1100011): 0, 10, 0, 0, 0, 1, ALUOp 01.
REQ-019 Any other opcode SHALL drive all decoder outputs to 0 and ALUOp to 00, so that no register write, memory write or branch occurs.
REQ-020 ALUOp 00 SHALL give ALUControl 000 (add).
REQ-021 ALUOp 01 SHALL give ALUControl 001 (subtract).
REQ-022 For ALUOp 10, ALUControl SHALL be selected by funct3:
- 000 with op[5]=1 and funct7_bit5=1: 001 (sub).
- 000 otherwise: 000 (add).
- 010: 101 (slt).
- 110: 011 (or).
- 111: 010 (and).
- any other funct3: 000.
REQ-023 PCSrc SHALL equal Branch AND Zero.
REQ-024 Zero SHALL affect no output other than PCSrc.
REQ-025 On each rising clk edge with reset=0, IllegalOp SHALL be set to 1 if op is not one of the five supported opcodes.
REQ-026 Once set, IllegalOp SHALL remain 1 until reset.
REQ-027 A supported op SHALL NOT clear IllegalOp.

Reset
REQ-028 On a rising clk edge with reset=1, IllegalOp SHALL be cleared to 0, taking priority over any simultaneous illegal opcode.
REQ-029 Reset SHALL NOT alter any combinational output; decode SHALL remain valid while reset is asserted, including when reset is asserted mid-operation.

Verification
REQ-030 op=0000011, funct3=010, Zero=0 -> PCSrc=0, ResultSrc=1, MemWrite=0, ALUControl=000, ALUSrc=1, ImmSrc=00, RegWrite=1.
REQ-031 op=0100011, funct3=010 -> PCSrc=0, ResultSrc=0, MemWrite=1, ALUControl=000, ALUSrc=1, ImmSrc=01, RegWrite=0.
REQ-032 op=0110011 with each funct3/funct7_bit5 pair -> RegWrite=1, ALUSrc=0, MemWrite=0, and ALUControl as follows:
- 000/0 (add): 000.
- 000/1 (sub): 001.
- 111/0 (and): 010.
- 110/0 (or): 011.
- 010/0 (slt): 101.
REQ-033 op=1100011, funct3=000 -> Zero=1 gives PCSrc=1 and Zero=0 gives PCSrc=0; in both cases ALUControl=001, ImmSrc=10, RegWrite=0, MemWrite=0, ALUSrc=0.
REQ-034 op=0010011, funct3=000, funct7_bit5=1 -> ALUControl=000 (add, not sub), ALUSrc=1, RegWrite=1.
REQ-035 Status-flag sequence:
- reset pulse -> IllegalOp=0.
- op=1111111 for one clk -> IllegalOp=1, with RegWrite=MemWrite=PCSrc=0.
- op=0000011 -> IllegalOp stays 1.
- reset pulse -> IllegalOp=0.
